spi_custom_master: RTL and testbench
====================================

# spi_custom_master

Master side of the team's custom 3-wire full-duplex SPI link (SCLK, MOSI, MISO). It generates a free-running SCLK and streams fixed-length frames on MOSI that the paired slave captures on every rising SCLK edge. It also receives the slave's unsolicited start-bit-framed words on MISO. It sits on the untrusted-IC side, directly facing the trusted IC's SPI slave, and exchanges KEY_LENGTH-bit words with local logic through a send/ready interface.

## Interface
- KEY_LENGTH, 32, payload width in bits; must be ≥ 2.
- CLK_DIV, 4, clk cycles per SCLK half-period; must be ≥ 3 because of the MISO synchronizer.

- clk  input  1  system clock; all state is in this domain.
- rst  input  1  asynchronous, active-high reset.
- dataToSend  input  KEY_LENGTH  word to transmit; sampled when a send is accepted.
- send  input  1  level request; accepted on any clk edge where it is high and tx_busy is low.
- tx_busy  output  1  high from acceptance until the frame's last bit period ends.
- tx_done  output  1  one-cycle pulse when a data frame completes.
- SCLK  output  1  serial clock to the slave.
- MOSI  output  1  serial data to the slave; changes only on falling SCLK events.
- MISO  input  1  serial data from the slave; asynchronous to clk.
- dataReceived  output  KEY_LENGTH  last correctly framed word; holds until the next one.
- dataReceived_ready  output  1  one-cycle pulse when dataReceived updates.
- rx_error  output  1  one-cycle pulse on a bad stop bit.

## Operation
- Reset values: SCLK=0, MOSI=0, tx_busy=0, tx_done=0, dataReceived=0, dataReceived_ready=0, rx_error=0. All counters are 0, the RX FSM is in RX_IDLE, and there is no pending word.
- SCLK divider: div_cnt counts 0..CLK_DIV-1. When div_cnt==CLK_DIV-1, SCLK toggles. A 0→1 toggle is a rise event; a 1→0 toggle is a fall event. SCLK never stops while rst is low.
- TX framing: the slave has no frame sync and counts rises modulo KEY_LENGTH+1. The master therefore keeps continuous back-to-back frames of KEY_LENGTH+1 bits with no gaps.
  - Bit positions 0..KEY_LENGTH-1 carry payload, LSB first.
  - Bit position KEY_LENGTH is a 0 trailer.
  - Frames with nothing pending are all-zero idle frames.
- The bit counter bit_cnt (0..KEY_LENGTH) advances on each fall event. MOSI is driven with the new bit at the same edge.
- On the fall event that wraps bit_cnt from KEY_LENGTH to 0:
  - If a word is pending, it becomes the active frame, is marked as a data frame, and MOSI takes its bit 0. Otherwise the active frame is all-zero.
  - If the frame just finished was a data frame, tx_done pulses and tx_busy drops in that same cycle.
- Frame 0 after reset is an idle frame; its bit 0 (0) is already on MOSI before the first rise.
- Send acceptance: send && !tx_busy latches dataToSend into the pending register and raises tx_busy on the next edge. send while tx_busy is high is ignored. There is no queue beyond one pending word.
- RX path: MISO passes through a 2-flop synchronizer (miso_s) and is sampled only on rise events.
- RX FSM:
  - RX_IDLE: miso_s==1 → RX_DATA with rx_cnt=0.
  - RX_DATA: rx_shift[rx_cnt] ← miso_s. When rx_cnt==KEY_LENGTH-1 → RX_STOP; otherwise rx_cnt+1.
  - RX_STOP: if miso_s==0, dataReceived ← rx_shift and pulse dataReceived_ready; otherwise pulse rx_error and leave dataReceived unchanged. Either way → RX_IDLE.
- RX is independent of TX frame alignment; a slave word may begin at any rise.

## Timing
- SCLK period is 2·CLK_DIV clk cycles. The first rise occurs CLK_DIV cycles after rst deasserts.
- One frame lasts (KEY_LENGTH+1)·2·CLK_DIV cycles.
- TX latency: a send accepted at a random point begins transmitting at the next frame boundary, up to one full frame later. tx_done follows the start of payload by exactly (KEY_LENGTH+1)·2·CLK_DIV cycles.
- A send accepted in the same cycle as a wrap fall event misses that boundary and goes out in the following frame.
- tx_done and dataReceived_ready/rx_error are registered pulses exactly one clk wide. They may coincide.
- RX latency: dataReceived_ready asserts in the cycle after the rise event that samples the stop bit.
- A MISO change must be stable ≥3 clk cycles before a rise event. This is guaranteed for slave transitions made on falling SCLK, given CLK_DIV ≥ 3.
- rst asserted mid-frame or mid-word immediately returns every register to its reset value. The pending word and any partial RX word are discarded, with no pulses.
- After rst, the slave must also be reset so that both sides agree on frame 0.

## Test plan
- KEY_LENGTH=8, CLK_DIV=4; reset, then send=1 with dataToSend=0xA5 → the next frame's MOSI sampled on rises is 1,0,1,0,0,1,0,1,0. tx_done pulses once; tx_busy is high from acceptance until tx_done.
- No send for 3 frames → MOSI stays 0 and SCLK toggles every 4 clk. Then a second send while the first is pending is ignored: only one data frame is sent.
- MISO model drives start 1, then 0x3C LSB first, then stop 0 on falling edges → dataReceived=0x3C with a single dataReceived_ready pulse; rx_error stays 0.
- Same stimulus with stop bit 1 → rx_error pulses once, dataReceived keeps its old value, and the FSM re-arms.
- Loopback with the slave model: master sends 0x5A while the slave simultaneously sends 0xC3 → the slave captures 0x5A and the master captures 0xC3, in the same frame period.
- rst asserted mid-TX and mid-RX → all outputs return to reset values, with no tx_done or ready pulse. After release, the next send of 0x01 transmits correctly.

Source files
------------

// File: rtl/spi_custom_master.sv
// spi_custom_master: master end of a 3-wire full-duplex SPI link.
// Drives a free-running SCLK and sends back-to-back frames of KEY_LENGTH+1
// bits on MOSI: the payload LSB first, then a 0 trailer. Frames with no
// word to send are all zero. It also receives start/stop-framed words from
// the slave on MISO.
module spi_custom_master #(
  parameter int KEY_LENGTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_LENGTH-1:0] dataToSend,
  input  logic                  send,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [KEY_LENGTH-1:0] dataReceived,
  output logic                  dataReceived_ready,
  output logic                  rx_error
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(KEY_LENGTH + 1);
  localparam int RXC_W = $clog2(KEY_LENGTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(KEY_LENGTH);
  localparam logic [RXC_W-1:0] RXC_LAST = RXC_W'(KEY_LENGTH - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // SCLK generation and TX framing state
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  sclk_q, sclk_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [KEY_LENGTH-1:0] tx_shift_q, tx_shift_d;
  logic                  data_frame_q, data_frame_d;
  logic [KEY_LENGTH-1:0] pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  tx_done_q, tx_done_d;

  // MISO synchronizer and RX state
  logic                  miso_meta_q, miso_meta_d;
  logic                  miso_s_q, miso_s_d;
  rx_state_e             rx_state_q, rx_state_d;
  logic [RXC_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [KEY_LENGTH-1:0] rx_shift_q, rx_shift_d;
  logic [KEY_LENGTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  rx_error_q, rx_error_d;

  logic sclk_tick;
  logic rise;
  logic fall;

  assign sclk_tick = (div_cnt_q == DIV_LAST);
  assign rise      = sclk_tick & ~sclk_q;
  assign fall      = sclk_tick &  sclk_q;

  // Next state for the divider, the bit counter, the active frame and the
  // one-deep pending slot.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    div_cnt_d    = div_cnt_q + DIV_W'(1);
    sclk_d       = sclk_q;
    bit_cnt_d    = bit_cnt_q;
    tx_shift_d   = tx_shift_q;
    data_frame_d = data_frame_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tx_busy_d    = tx_busy_q;
    tx_done_d    = 1'b0;

    if (sclk_tick) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end

    if (fall) begin
      if (bit_cnt_q == BIT_LAST) begin
        // Frame boundary. Start the pending word if there is one, else send an idle frame.
        bit_cnt_d    = '0;
        tx_shift_d   = pend_valid_q ? pend_q : '0;
        data_frame_d = pend_valid_q;
        pend_valid_d = 1'b0;
        if (data_frame_q) begin
          tx_done_d = 1'b1;
          tx_busy_d = 1'b0;
        end
      end else begin
        // Shift in zeros so that bit 0 is 0 when the trailer position comes up.
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        tx_shift_d = tx_shift_q >> 1;
      end
    end

    // A word that arrives on a boundary edge waits here until the next boundary.
    if (send && !tx_busy_q) begin
      pend_d       = dataToSend;
      pend_valid_d = 1'b1;
      tx_busy_d    = 1'b1;
    end
  end

  // Registers for SCLK and the TX path
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers take the async reset too, so every output reads 0 straight out of reset.
    if (rst) begin
      div_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      bit_cnt_q    <= '0;
      tx_shift_q   <= '0;
      data_frame_q <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge value of the others.
      div_cnt_q    <= div_cnt_d;
      sclk_q       <= sclk_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      data_frame_q <= data_frame_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tx_busy_q    <= tx_busy_d;
      tx_done_q    <= tx_done_d;
    end
  end

  // RX FSM: start bit, KEY_LENGTH data bits LSB first, stop bit. It samples only on rise events.
  always_comb begin
    miso_meta_d = MISO;
    miso_s_d    = miso_meta_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_ready_d  = 1'b0;
    rx_error_d  = 1'b0;

    if (rise) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (miso_s_q) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = '0;
          end
        end
        RX_DATA: begin
          // The first bit enters at the MSB. After KEY_LENGTH shifts it sits at bit 0.
          rx_shift_d = {miso_s_q, rx_shift_q[KEY_LENGTH-1:1]};
          if (rx_cnt_q == RXC_LAST) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + RXC_W'(1);
          end
        end
        RX_STOP: begin
          if (!miso_s_q) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
          end else begin
            rx_error_d = 1'b1;
          end
          rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // Registers for the MISO synchronizer and the RX path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_meta_q <= 1'b0;
      miso_s_q    <= 1'b0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      miso_meta_q <= miso_meta_d;
      miso_s_q    <= miso_s_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      rx_error_q  <= rx_error_d;
    end
  end

  assign SCLK               = sclk_q;
  assign MOSI               = tx_shift_q[0];
  assign tx_busy            = tx_busy_q;
  assign tx_done            = tx_done_q;
  assign dataReceived       = rx_data_q;
  assign dataReceived_ready = rx_ready_q;
  assign rx_error           = rx_error_q;

endmodule

// File: tb/tb_spi_custom_master.sv
// Directed testbench for spi_custom_master (KEY_LENGTH=8, CLK_DIV=4).
// Contains a slave model that captures MOSI on rising SCLK, plus a MISO
// driver that changes its output on falling SCLK.
module tb_spi_custom_master;

  localparam int KL    = 8;
  localparam int CD    = 4;
  localparam int FRAME = (KL + 1) * 2 * CD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [KL-1:0] dataToSend = '0;
  logic          send = 1'b0;
  logic          tx_busy;
  logic          tx_done;
  logic          SCLK;
  logic          MOSI;
  logic          MISO = 1'b0;
  logic [KL-1:0] dataReceived;
  logic          dataReceived_ready;
  logic          rx_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse counters. A single-cycle pulse adds exactly one.
  int n_done  = 0;
  int n_ready = 0;
  int n_err   = 0;

  // Slave model state
  int            s_pos         = 0;
  logic [KL-1:0] s_shift       = '0;
  logic [KL-1:0] s_word        = '0;
  int            s_data_frames = 0;
  int            s_bad_trailer = 0;

  // MISO driver. The stimulus posts a pattern and bumps m_kick to start it.
  logic [KL+1:0] m_pat_req = '0;
  int            m_kick    = 0;
  logic [KL+1:0] m_pat     = '0;
  int            m_left    = 0;
  int            m_seen    = 0;

  spi_custom_master #(
    .KEY_LENGTH(KL),
    .CLK_DIV   (CD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .dataToSend        (dataToSend),
    .send              (send),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .SCLK              (SCLK),
    .MOSI              (MOSI),
    .MISO              (MISO),
    .dataReceived      (dataReceived),
    .dataReceived_ready(dataReceived_ready),
    .rx_error          (rx_error)
  );

  always #5 clk = ~clk;

  // Slave: counts rises modulo KL+1. It captures the payload LSB first and checks the trailer.
  always @(posedge SCLK or posedge rst) begin
    if (rst) begin
      s_pos   = 0;
      s_shift = '0;
    end else if (s_pos == KL) begin
      s_word = s_shift;
      if (s_shift != '0) s_data_frames++;
      if (MOSI !== 1'b0) s_bad_trailer++;
      s_pos = 0;
    end else begin
      s_shift = {MOSI, s_shift[KL-1:1]};
      s_pos++;
    end
  end

  // Slave transmitter: puts one pattern bit on MISO at each falling SCLK, LSB first.
  always @(negedge SCLK or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_seen = m_kick;
      MISO   = 1'b0;
    end else begin
      if (m_seen != m_kick) begin
        m_seen = m_kick;
        m_pat  = m_pat_req;
        m_left = KL + 2;
      end
      if (m_left > 0) begin
        MISO  = m_pat[0];
        m_pat = m_pat >> 1;
        m_left--;
      end else begin
        MISO = 1'b0;
      end
    end
  end

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (tx_done === 1'b1)            n_done++;
    if (dataReceived_ready === 1'b1) n_ready++;
    if (rx_error === 1'b1)           n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for output 0=tx_done, 1=dataReceived_ready or 2=rx_error, up to budget cycles.
  task automatic wait_high(input int which, input int budget, output bit ok);
    logic sel;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      sel = (which == 0) ? tx_done : (which == 1) ? dataReceived_ready : rx_error;
      if (sel === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit ok;
    bit got_tx;
    bit got_rx;
    int since;
    int toggles;
    int bad_period;
    int mosi_hi;
    int busy_low;
    int lat;
    logic prev_sclk;
    int base_done;
    int base_ready;
    int base_err;
    int base_frames;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sclk",    32'(SCLK),               32'd0);
    check("rst_mosi",    32'(MOSI),               32'd0);
    check("rst_busy",    32'(tx_busy),            32'd0);
    check("rst_done",    32'(tx_done),            32'd0);
    check("rst_rxdata",  32'(dataReceived),       32'd0);
    check("rst_ready",   32'(dataReceived_ready), 32'd0);
    check("rst_rxerr",   32'(rx_error),           32'd0);

    // The first rise comes CLK_DIV cycles after reset is released
    rst = 1'b0;
    repeat (CD - 1) @(negedge clk);
    check("pre_first_rise", 32'(SCLK), 32'd0);
    @(negedge clk);
    check("first_rise",      32'(SCLK), 32'd1);
    check("frame0_bit0",     32'(MOSI), 32'd0);

    // Three idle frames: SCLK toggles every CD clocks and MOSI stays 0
    since = 0; toggles = 0; bad_period = 0; mosi_hi = 0; prev_sclk = SCLK;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      since++;
      if (SCLK !== prev_sclk) begin
        if (since != CD) bad_period++;
        toggles++;
        since = 0;
        prev_sclk = SCLK;
      end
      if (MOSI !== 1'b0) mosi_hi++;
    end
    check("idle_toggles",    32'(toggles),       32'(3 * FRAME / CD));
    check("idle_period",     32'(bad_period),    32'd0);
    check("idle_mosi",       32'(mosi_hi),       32'd0);
    check("idle_no_frames",  32'(s_data_frames), 32'd0);

    // Send 0xA5. A second send while busy must be ignored.
    base_done = n_done; base_frames = s_data_frames;
    dataToSend = 8'hA5; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("busy_on_accept", 32'(tx_busy), 32'd1);
    dataToSend = 8'h77; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("busy_hold", 32'(tx_busy), 32'd1);
    ok = 1'b0; busy_low = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (tx_busy !== 1'b1) busy_low++;
    end
    check("a5_done_seen",     32'(ok),       32'd1);
    check("a5_busy_drops",    32'(tx_busy),  32'd0);
    check("a5_busy_steady",   32'(busy_low), 32'd0);
    check("a5_slave_word",    32'(s_word),   32'hA5);
    repeat (2 * FRAME) @(negedge clk);
    check("a5_one_done",      32'(n_done - base_done),             32'd1);
    check("a5_one_frame",     32'(s_data_frames - base_frames),    32'd1);
    check("a5_trailers",      32'(s_bad_trailer),                  32'd0);

    // RX: good word 0x3C
    base_ready = n_ready; base_err = n_err;
    m_pat_req = {1'b0, 8'h3C, 1'b1}; m_kick++;
    wait_high(1, 200, ok);
    check("rx3c_ready_seen", 32'(ok),           32'd1);
    check("rx3c_data",       32'(dataReceived), 32'h3C);
    repeat (20) @(negedge clk);
    check("rx3c_one_ready",  32'(n_ready - base_ready), 32'd1);
    check("rx3c_no_error",   32'(n_err - base_err),     32'd0);

    // RX: bad stop bit. Data is kept and the FSM re-arms.
    base_ready = n_ready; base_err = n_err;
    m_pat_req = {1'b1, 8'h96, 1'b1}; m_kick++;
    wait_high(2, 200, ok);
    check("rxbad_err_seen",  32'(ok),           32'd1);
    check("rxbad_data_kept", 32'(dataReceived), 32'h3C);
    repeat (20) @(negedge clk);
    check("rxbad_one_err",   32'(n_err - base_err),     32'd1);
    check("rxbad_no_ready",  32'(n_ready - base_ready), 32'd0);
    m_pat_req = {1'b0, 8'h81, 1'b1}; m_kick++;
    wait_high(1, 200, ok);
    check("rearm_ready_seen", 32'(ok),           32'd1);
    check("rearm_data",       32'(dataReceived), 32'h81);

    // Loopback: both directions at the same time
    dataToSend = 8'h5A; send = 1'b1;
    m_pat_req = {1'b0, 8'hC3, 1'b1}; m_kick++;
    @(negedge clk);
    send = 1'b0;
    got_tx = 1'b0; got_rx = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) got_tx = 1'b1;
      if (dataReceived_ready === 1'b1) got_rx = 1'b1;
      if (got_tx && got_rx) break;
    end
    check("loop_tx_done",  32'(got_tx),       32'd1);
    check("loop_rx_ready", 32'(got_rx),       32'd1);
    check("loop_slave",    32'(s_word),       32'h5A);
    check("loop_master",   32'(dataReceived), 32'hC3);

    // Reset in the middle of a TX frame and an RX word
    dataToSend = 8'hFF; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (MOSI === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("ff_frame_started", 32'(ok), 32'd1);
    m_pat_req = {1'b0, 8'h55, 1'b1}; m_kick++;
    repeat (30) @(negedge clk);
    check("ff_midframe_busy", 32'(tx_busy), 32'd1);
    base_done = n_done; base_ready = n_ready; base_err = n_err; base_frames = s_data_frames;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sclk",   32'(SCLK),               32'd0);
    check("mid_rst_mosi",   32'(MOSI),               32'd0);
    check("mid_rst_busy",   32'(tx_busy),            32'd0);
    check("mid_rst_done",   32'(tx_done),            32'd0);
    check("mid_rst_rxdata", 32'(dataReceived),       32'd0);
    check("mid_rst_ready",  32'(dataReceived_ready), 32'd0);
    check("mid_rst_rxerr",  32'(rx_error),           32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    check("post_rst_no_done",   32'(n_done - base_done),          32'd0);
    check("post_rst_no_ready",  32'(n_ready - base_ready),        32'd0);
    check("post_rst_no_err",    32'(n_err - base_err),            32'd0);
    check("post_rst_no_frame",  32'(s_data_frames - base_frames), 32'd0);
    check("post_rst_idle",      32'(tx_busy),                     32'd0);

    // Send 0x01 after reset. tx_done comes exactly one frame after payload bit 0 appears.
    dataToSend = 8'h01; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (MOSI === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("x01_started", 32'(ok), 32'd1);
    lat = 0; got_tx = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      lat++;
      if (tx_done === 1'b1) begin
        got_tx = 1'b1;
        break;
      end
    end
    check("x01_done_seen",   32'(got_tx),        32'd1);
    check("x01_latency",     32'(lat),           32'(FRAME));
    check("x01_slave_word",  32'(s_word),        32'h01);
    check("x01_rxdata_zero", 32'(dataReceived),  32'd0);
    check("x01_trailers",    32'(s_bad_trailer), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
